// File: rtl/reg_text_scanner_pkg.sv
// Shared constants and FSM encoding for the register-file text dumper.
// ASCII codes, the fixed text colour and the scanner state enum live here.
package reg_text_scanner_pkg;

  localparam logic [7:0]  ZERO        = 8'h30;
  localparam logic [7:0]  A_UP        = 8'h41;
  localparam logic [7:0]  PLUS        = 8'h2B;
  localparam logic [7:0]  MINUS       = 8'h2D;
  localparam logic [7:0]  SPACE       = 8'h20;
  localparam logic [7:0]  H_LOW       = 8'h68;
  localparam logic [23:0] TEXT_COLOUR = 24'hFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CONV,
    ST_EMIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? ZERO + {4'd0, nib} : A_UP + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/reg_text_scanner_if.sv
// Text-buffer write port between the scanner (master) and the text-mode controller (slave).
interface reg_text_scanner_if #(
  parameter int ADDR_W = 13
) ();

  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/reg_text_scanner_bin2bcd.sv
// Sequential double-dabble converter: one shift per cycle, DATA_W cycles after i_start.
// o_done is high during the cycle whose closing edge performs the final shift.
module reg_text_scanner_bin2bcd #(
  parameter int DATA_W     = 32,
  parameter int DEC_DIGITS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [DATA_W-1:0]       i_bin,
  output logic                    o_done,
  output logic [DEC_DIGITS*4-1:0] o_bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]       r_bin;
  logic [DEC_DIGITS*4-1:0] r_bcd;
  logic [CNT_W-1:0]        r_cnt;
  logic [DEC_DIGITS*4-1:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < DEC_DIGITS; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= CNT_W'(DATA_W);
    end else if (r_cnt != '0) begin
      r_bcd <= {w_adj[DEC_DIGITS*4-2:0], r_bin[DATA_W-1]};
      r_bin <= {r_bin[DATA_W-2:0], 1'b0};
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/reg_text_scanner.sv
// Scans NUM_REGS registers and streams one formatted text row per register
// (signed decimal or hex, chosen per frame) into the text buffer.
module reg_text_scanner
  import reg_text_scanner_pkg::*;
#(
  parameter int NUM_REGS   = 33,
  parameter int DATA_W     = 32,
  parameter int DEC_DIGITS = 10,
  parameter int COLS       = 80,
  parameter int ADDR_W     = 13,
  parameter int ROW_BASE   = 0,
  parameter int COL_BASE   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REGS*DATA_W-1:0] i_reg_flat,
  input  logic                       i_run,
  input  logic                       i_mode_hex,
  reg_text_scanner_if.master         wr,
  output logic                       o_busy,
  output logic                       o_frame_done
);

  localparam int LINE_LEN   = 1 + DEC_DIGITS;
  localparam int HEX_DIGITS = DATA_W / 4;
  localparam int ROW_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int COL_W      = $clog2(LINE_LEN + 1);

  state_t                  r_state, w_next;
  logic [ROW_W-1:0]        r_row;
  logic [COL_W-1:0]        r_col;
  logic                    r_mode;
  logic                    r_neg;
  logic [DATA_W-1:0]       r_mag;

  logic [DATA_W-1:0]       w_row_val;
  logic                    w_neg;
  logic [DATA_W-1:0]       w_mag;
  logic                    w_accept;
  logic                    w_last_col;
  logic                    w_last_row;
  logic                    w_bcd_start;
  logic                    w_bcd_done;
  logic [DEC_DIGITS*4-1:0] w_bcd;
  logic [7:0]              w_ascii;
  int                      w_dig_idx;
  int                      w_nib_idx;

  assign w_row_val   = i_reg_flat[r_row*DATA_W +: DATA_W];
  assign w_neg       = w_row_val[DATA_W-1] & ~r_mode;
  assign w_mag       = w_neg ? (~w_row_val + DATA_W'(1)) : w_row_val;
  assign w_accept    = (r_state == ST_EMIT) & wr.wr_ready;
  assign w_last_col  = (r_col == COL_W'(LINE_LEN - 1));
  assign w_last_row  = (r_row == ROW_W'(NUM_REGS - 1));
  assign w_bcd_start = (r_state == ST_LOAD) & ~r_mode;

  reg_text_scanner_bin2bcd #(
    .DATA_W     (DATA_W),
    .DEC_DIGITS (DEC_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_bcd_start),
    .i_bin   (w_mag),
    .o_done  (w_bcd_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // state | meaning
  // IDLE  | waiting for run; mode latched on start
  // LOAD  | snapshot row value, sign and magnitude; kick BCD in decimal mode
  // CONV  | DATA_W-cycle BCD conversion (decimal only)
  // EMIT  | one cell per accepted write, col 0..LINE_LEN-1
  // NEXT  | advance row or finish frame
  // DONE  | frame_done pulse; restart or go idle depending on run
  always_comb begin
    w_next       = r_state;
    wr.wr_en     = 1'b0;
    o_busy       = 1'b1;
    o_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_run) w_next = ST_LOAD;
      end
      ST_LOAD: w_next = r_mode ? ST_EMIT : ST_CONV;
      ST_CONV: if (w_bcd_done) w_next = ST_EMIT;
      ST_EMIT: begin
        wr.wr_en = 1'b1;
        if (wr.wr_ready && w_last_col) w_next = ST_NEXT;
      end
      ST_NEXT: w_next = w_last_row ? ST_DONE : ST_LOAD;
      ST_DONE: begin
        o_frame_done = 1'b1;
        w_next       = i_run ? ST_LOAD : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_mode <= 1'b0;
      r_neg  <= 1'b0;
      r_mag  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_run) begin
            r_mode <= i_mode_hex;
            r_row  <= '0;
          end
        end
        ST_LOAD: begin
          r_neg <= w_neg;
          r_mag <= w_mag;
          r_col <= '0;
        end
        ST_EMIT: if (w_accept) r_col <= r_col + COL_W'(1);
        ST_NEXT: if (!w_last_row) r_row <= r_row + ROW_W'(1);
        default: ;
      endcase
    end
  end

  assign w_dig_idx = DEC_DIGITS - int'(r_col);
  assign w_nib_idx = HEX_DIGITS - int'(r_col);

  // Hex rows are shorter than decimal ones; pad with spaces so old digits get overwritten.
  always_comb begin
    w_ascii = SPACE;
    if (r_col == '0) begin
      w_ascii = r_mode ? H_LOW : (r_neg ? MINUS : PLUS);
    end else if (!r_mode && int'(r_col) <= DEC_DIGITS) begin
      w_ascii = ZERO + {4'd0, w_bcd[w_dig_idx*4 +: 4]};
    end else if (r_mode && int'(r_col) <= HEX_DIGITS) begin
      w_ascii = hex_ascii(r_mag[w_nib_idx*4 +: 4]);
    end
  end

  assign wr.wr_addr = (r_state == ST_EMIT) ?
                      ADDR_W'((ROW_BASE + int'(r_row)) * COLS + COL_BASE + int'(r_col)) : '0;
  assign wr.wr_data = (r_state == ST_EMIT) ? {w_ascii, TEXT_COLOUR} : '0;

endmodule

// File: tb/tb_reg_text_scanner.sv
// Self-checking bench for reg_text_scanner: randomized register contents checked
// against a string-formatting reference model, plus handshake, restart and reset scenarios.
module tb_reg_text_scanner;

  localparam int NR   = 33;
  localparam int DW   = 32;
  localparam int LL   = 11;
  localparam int COLS = 80;
  localparam int AW   = 13;
  localparam int DEC_ROW_CYC = 1 + DW + LL + 1;
  localparam int HEX_ROW_CYC = 1 + LL + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [31:0]     regs [NR];
  logic [31:0]     snap [NR];
  logic [NR*DW-1:0] reg_flat;
  logic            run = 1'b0;
  logic            mode_hex = 1'b0;
  logic            busy;
  logic            frame_done;

  int total = 0;
  int bad   = 0;

  logic [AW+31:0] got_q [$];
  logic [AW+31:0] exp_q [$];
  int   fd_rises = 0;
  int   fd_cycles = 0;
  logic fd_prev = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    reg_flat = '0;
    for (int i = 0; i < NR; i++) reg_flat[i*DW +: DW] = regs[i];
  end

  reg_text_scanner_if #(.ADDR_W(AW)) wr_if ();

  reg_text_scanner dut (
    .clk          (clk),
    .rst          (rst),
    .i_reg_flat   (reg_flat),
    .i_run        (run),
    .i_mode_hex   (mode_hex),
    .wr           (wr_if),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  // Writes are recorded half a cycle before the edge that accepts them.
  always @(negedge clk) begin
    if (rst && wr_if.wr_en && wr_if.wr_ready) got_q.push_back({wr_if.wr_addr, wr_if.wr_data});
    if (frame_done) begin
      fd_cycles++;
      if (!fd_prev) fd_rises++;
    end
    fd_prev = frame_done;
  end

  function automatic logic [7:0] model_char(input logic [31:0] v, input bit hex, input int col);
    longint mag;
    longint p;
    int     nib;
    if (hex) begin
      if (col == 0) return 8'h68;
      if (col > DW/4) return 8'h20;
      nib = int'((v >> (4*(DW/4 - col))) & 32'hF);
      return (nib < 10) ? 8'(8'h30 + nib) : 8'(8'h37 + nib);
    end
    mag = longint'($signed(v));
    if (col == 0) return (mag < 0) ? 8'h2D : 8'h2B;
    if (mag < 0) mag = -mag;
    p = 1;
    for (int i = 0; i < (LL - 1) - col; i++) p = p * 10;
    return 8'(8'h30 + ((mag / p) % 10));
  endfunction

  task automatic build_expected(input bit hex);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < LL; c++)
        exp_q.push_back({AW'(r*COLS + c), model_char(snap[r], hex, c), 24'hFFFFFF});
  endtask

  task automatic clear_scoreboard();
    got_q.delete();
    exp_q.delete();
    fd_rises  = 0;
    fd_cycles = 0;
  endtask

  task automatic rand_regs();
    for (int i = 0; i < NR; i++) begin
      case ($urandom_range(0, 3))
        0:       regs[i] = $urandom();
        1:       regs[i] = $urandom_range(0, 99999);
        2:       regs[i] = 32'd0 - $urandom_range(1, 99999);
        default: regs[i] = (i % 2 == 1) ? 32'h7FFFFFFF : 32'hFFFFFFFF;
      endcase
    end
  endtask

  task automatic run_one_frame(output int busy_cyc, output bit ok);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    busy_cyc = 0;
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      else begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_writes(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (wr_if.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", wr_if.wr_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    total++; if (wr_if.wr_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", wr_if.wr_addr); end
    total++; if (wr_if.wr_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", wr_if.wr_data); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || wr_if.wr_en !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b wr_en=%b want=0,0", busy, wr_if.wr_en); end
  endtask

  task automatic test_dec_frame();
    int    cyc;
    bit    ok;
    int    lr [3] = '{5, 32, 0};
    string ls [3] = '{"-0000001234", "-2147483648", "+0000000000"};
    string s;
    rand_regs();
    regs[0]  = 32'd0;
    regs[5]  = 32'd0 - 32'd1234;
    regs[32] = 32'h80000000;
    mode_hex = 1'b0;
    clear_scoreboard();
    snap = regs;
    build_expected(1'b0);
    run_one_frame(cyc, ok);
    total++; if (!ok) begin bad++; $display("FAIL dec_timeout got=busy_stuck want=idle"); end
    total++; if (cyc !== NR*DEC_ROW_CYC + 1) begin bad++; $display("FAIL dec_latency got=%0d want=%0d", cyc, NR*DEC_ROW_CYC + 1); end
    total++; if (fd_rises !== 1 || fd_cycles !== 1) begin bad++; $display("FAIL dec_frame_done got=%0d/%0d want=1/1", fd_rises, fd_cycles); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL dec_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL dec_cell %0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    for (int k = 0; k < 3; k++) begin
      s = ls[k];
      for (int c = 0; c < LL; c++) begin
        total++;
        if (got_q.size() <= lr[k]*LL + c || got_q[lr[k]*LL + c][31:24] !== s[c]) begin
          bad++; $display("FAIL dec_text row%0d col%0d want=%h", lr[k], c, s[c]);
        end
      end
    end
  endtask

  task automatic test_hex_frame();
    int    cyc;
    bit    ok;
    string s;
    rand_regs();
    regs[1]  = 32'hDEADBEEF;
    mode_hex = 1'b1;
    clear_scoreboard();
    snap = regs;
    build_expected(1'b1);
    run_one_frame(cyc, ok);
    total++; if (!ok) begin bad++; $display("FAIL hex_timeout got=busy_stuck want=idle"); end
    total++; if (cyc !== NR*HEX_ROW_CYC + 1) begin bad++; $display("FAIL hex_latency got=%0d want=%0d", cyc, NR*HEX_ROW_CYC + 1); end
    total++; if (fd_rises !== 1 || fd_cycles !== 1) begin bad++; $display("FAIL hex_frame_done got=%0d/%0d want=1/1", fd_rises, fd_cycles); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL hex_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL hex_cell %0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
    s = "hDEADBEEF  ";
    for (int c = 0; c < LL; c++) begin
      total++;
      if (got_q.size() <= LL + c || got_q[LL + c][AW+31:24] !== {AW'(COLS + c), s[c]}) begin
        bad++; $display("FAIL hex_text row1 col%0d want=%h", c, s[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit             ok;
    logic [AW-1:0]  held_addr;
    logic [31:0]    held_data;
    rand_regs();
    mode_hex = 1'b0;
    clear_scoreboard();
    snap = regs;
    build_expected(1'b0);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    wait_writes(2*LL + 4, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_wait got=timeout want=writes"); end
    @(posedge clk);
    #1 wr_if.wr_ready = 1'b0;
    held_addr = wr_if.wr_addr;
    held_data = wr_if.wr_data;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (wr_if.wr_en !== 1'b1 || wr_if.wr_addr !== held_addr || wr_if.wr_data !== held_data) begin
        bad++; $display("FAIL bp_hold got=%b/%h/%h want=1/%h/%h", wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, held_addr, held_data);
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      @(posedge clk);
      #1 wr_if.wr_ready = 1'($urandom_range(0, 1));
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    wr_if.wr_ready = 1'b1;
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=busy_stuck want=idle"); end
    total++; if (fd_rises !== 1 || fd_cycles !== 1) begin bad++; $display("FAIL bp_frame_done got=%0d/%0d want=1/1", fd_rises, fd_cycles); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_cell %0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seen;
    int busy_low;
    int cyc;
    rand_regs();
    mode_hex = 1'b0;
    clear_scoreboard();
    snap = regs;
    build_expected(1'b0);
    run = 1'b1;
    wait_writes(7*LL + 3, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_wait got=timeout want=writes"); end
    @(posedge clk);
    #1;
    regs[7]  = regs[7] ^ 32'h0F0F1234;
    mode_hex = 1'b1;
    snap = regs;
    build_expected(1'b1);
    seen = 1'b0;
    busy_low = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL b2b_first_done got=none want=pulse"); end
    @(posedge clk);
    #1 run = 1'b0;
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (busy) cyc++;
      else begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=busy_stuck want=idle"); end
    total++; if (busy_low !== 0) begin bad++; $display("FAIL b2b_busy_gap got=%0d want=0", busy_low); end
    total++; if (cyc !== NR*HEX_ROW_CYC + 1) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", cyc, NR*HEX_ROW_CYC + 1); end
    total++; if (fd_rises !== 2 || fd_cycles !== 2) begin bad++; $display("FAIL b2b_frame_done got=%0d/%0d want=2/2", fd_rises, fd_cycles); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_cell %0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_emit();
    bit ok;
    int cyc;
    rand_regs();
    mode_hex = 1'b0;
    clear_scoreboard();
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    wait_writes(12*LL + 4, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_wait got=timeout want=writes"); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if (wr_if.wr_en !== 1'b0) begin bad++; $display("FAIL rst_mid_wr_en got=%b want=0", wr_if.wr_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    @(negedge clk);
    rst = 1'b1;
    clear_scoreboard();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_resumed got=%b want=0", busy); end
    rand_regs();
    mode_hex = 1'b1;
    snap = regs;
    build_expected(1'b1);
    run_one_frame(cyc, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_timeout got=busy_stuck want=idle"); end
    total++; if (got_q.size() == 0 || got_q[0][AW+31:32] !== AW'(0)) begin bad++; $display("FAIL rst_first_addr got=%h want=0", (got_q.size() == 0) ? '0 : got_q[0][AW+31:32]); end
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rst_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rst_cell %0d got=%h want=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = '0;
    wr_if.wr_ready = 1'b1;
    test_reset();
    test_dec_frame();
    test_hex_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_emit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
